// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_decode
// Brief    : Serial byte instruction fetch and RV32E OP/OP-IMM decode stage.
// Revision : 1.0
// ============================================================================
module instr_fetch_decode #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        abort,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic [3:0]  rd,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic        illegal
);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  localparam logic [6:0] c_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_F7_ALT = 7'b0100000;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic        r_byte_ready;
  logic        r_dec_valid;
  logic [31:0] r_instr;
  logic [3:0]  r_alu_op;
  logic [3:0]  r_rd;
  logic [3:0]  r_rs1;
  logic [3:0]  r_rs2;
  logic [31:0] r_imm;
  logic        r_use_imm;
  logic        r_illegal;

  logic        w_accept;
  logic [1:0]  w_lane;
  logic [31:0] w_word;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_f7;
  logic        w_legal;
  logic        w_rs2_used;
  logic        w_ok;
  logic [3:0]  w_alu_op;
  logic [31:0] w_imm;
  logic        w_use_imm;

  assign w_accept = byte_valid && r_byte_ready;
  assign w_lane   = BIG_ENDIAN ? (2'd3 - r_cnt) : r_cnt;

  // Word as it will look once the incoming byte lands in its lane.
  always_comb begin
    w_word = r_instr;
    w_word[{w_lane, 3'b000} +: 8] = byte_in;
  end

  assign w_opcode = w_word[6:0];
  assign w_rd     = w_word[11:7];
  assign w_f3     = w_word[14:12];
  assign w_rs1    = w_word[19:15];
  assign w_rs2    = w_word[24:20];
  assign w_f7     = w_word[31:25];

  always_comb begin
    w_legal    = 1'b0;
    w_rs2_used = 1'b0;
    w_alu_op   = 4'd0;
    w_imm      = 32'd0;
    w_use_imm  = 1'b0;
    case (w_opcode)
      c_OP: begin
        w_rs2_used = 1'b1;
        w_alu_op   = {w_word[30], w_f3};
        w_legal    = (w_f7 == 7'd0) ||
                     ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      c_OP_IMM: begin
        w_use_imm = 1'b1;
        case (w_f3)
          3'b001: begin
            w_legal  = (w_f7 == 7'd0);
            w_alu_op = 4'b0001;
            w_imm    = {27'd0, w_word[24:20]};
          end
          3'b101: begin
            w_legal  = (w_f7 == 7'd0) || (w_f7 == c_F7_ALT);
            w_alu_op = {w_word[30], 3'b101};
            w_imm    = {27'd0, w_word[24:20]};
          end
          default: begin
            w_legal  = 1'b1;
            w_alu_op = {1'b0, w_f3};
            w_imm    = {{20{w_word[31]}}, w_word[31:20]};
          end
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  // RV32E only has x0..x15, so bit 4 of any used register field is illegal.
  assign w_ok = w_legal && !w_rd[4] && !w_rs1[4] && !(w_rs2_used && w_rs2[4]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_COLLECT;
      r_cnt        <= 2'd0;
      r_byte_ready <= 1'b0;
      r_dec_valid  <= 1'b0;
      r_instr      <= 32'd0;
      r_alu_op     <= 4'd0;
      r_rd         <= 4'd0;
      r_rs1        <= 4'd0;
      r_rs2        <= 4'd0;
      r_imm        <= 32'd0;
      r_use_imm    <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (abort) begin
      r_state      <= S_COLLECT;
      r_cnt        <= 2'd0;
      r_byte_ready <= 1'b1;
      r_dec_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          r_byte_ready <= 1'b1;
          if (w_accept) begin
            r_instr <= w_word;
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state      <= S_HOLD;
              r_byte_ready <= 1'b0;
              r_dec_valid  <= 1'b1;
              r_alu_op     <= w_ok ? w_alu_op : 4'd0;
              r_rd         <= w_ok ? w_rd[3:0] : 4'd0;
              r_rs1        <= w_ok ? w_rs1[3:0] : 4'd0;
              r_rs2        <= (w_ok && w_rs2_used) ? w_rs2[3:0] : 4'd0;
              r_imm        <= w_ok ? w_imm : 32'd0;
              r_use_imm    <= w_ok ? w_use_imm : 1'b0;
              r_illegal    <= !w_ok;
            end
          end
        end
        S_HOLD: begin
          if (dec_ready) begin
            r_state      <= S_COLLECT;
            r_cnt        <= 2'd0;
            r_byte_ready <= 1'b1;
            r_dec_valid  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_COLLECT;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign dec_valid  = r_dec_valid;
  assign instr      = r_instr;
  assign alu_op     = r_alu_op;
  assign rd         = r_rd;
  assign rs1        = r_rs1;
  assign rs2        = r_rs2;
  assign imm        = r_imm;
  assign use_imm    = r_use_imm;
  assign illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_decode
// Brief    : Directed scoreboard bench for instr_fetch_decode (LE and BE instances).
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_decode;

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  alu_op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        abort = 1'b0;
  logic        dec_ready = 1'b0;

  logic        byte_ready, dec_valid, use_imm, illegal;
  logic [31:0] instr, imm;
  logic [3:0]  alu_op, rd, rs1, rs2;

  logic        be_byte_ready, be_dec_valid, be_use_imm, be_illegal;
  logic [31:0] be_instr, be_imm;
  logic [3:0]  be_alu_op, be_rd, be_rs1, be_rs2;

  int checks = 0;
  int errors = 0;
  dec_t sb[$];

  always #5 clk = ~clk;

  instr_fetch_decode #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .abort(abort), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .instr(instr), .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .use_imm(use_imm), .illegal(illegal)
  );

  instr_fetch_decode #(.BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(be_byte_ready), .abort(abort), .dec_valid(be_dec_valid), .dec_ready(dec_ready),
    .instr(be_instr), .alu_op(be_alu_op), .rd(be_rd), .rs1(be_rs1), .rs2(be_rs2), .imm(be_imm),
    .use_imm(be_use_imm), .illegal(be_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic dec_t mk(input logic [31:0] w, input logic [3:0] op, input logic [3:0] d,
                              input logic [3:0] s1, input logic [3:0] s2, input logic [31:0] im,
                              input logic ui, input logic il);
    dec_t e;
    e.instr = w; e.alu_op = op; e.rd = d; e.rs1 = s1; e.rs2 = s2;
    e.imm = im; e.use_imm = ui; e.illegal = il;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      acc = byte_ready;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  // Little-endian byte order; checks the one-cycle decode latency.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    chk("latency_dec_valid", {31'd0, dec_valid}, 32'd1);
    chk("hold_byte_ready", {31'd0, byte_ready}, 32'd0);
  endtask

  task automatic check_out();
    dec_t e;
    for (int n = 0; n < 20 && !dec_valid; n++) begin
      @(posedge clk);
      #1;
    end
    chk("dec_valid_wait", {31'd0, dec_valid}, 32'd1);
    chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("instr", instr, e.instr);
      chk("alu_op", {28'd0, alu_op}, {28'd0, e.alu_op});
      chk("rd", {28'd0, rd}, {28'd0, e.rd});
      chk("rs1", {28'd0, rs1}, {28'd0, e.rs1});
      chk("rs2", {28'd0, rs2}, {28'd0, e.rs2});
      chk("imm", imm, e.imm);
      chk("use_imm", {31'd0, use_imm}, {31'd0, e.use_imm});
      chk("illegal", {31'd0, illegal}, {31'd0, e.illegal});
    end
    dec_ready = 1'b1;
    @(posedge clk);
    #1;
    dec_ready = 1'b0;
    chk("dec_valid_drop", {31'd0, dec_valid}, 32'd0);
    chk("byte_ready_back", {31'd0, byte_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_byte_ready", {31'd0, byte_ready}, 32'd1);

    // ADD, SUB, ADDI back-to-back
    sb.push_back(mk(32'h003100B3, 4'b0000, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0, 1'b0));
    send_word(32'h003100B3);
    check_out();
    sb.push_back(mk(32'h403100B3, 4'b1000, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0, 1'b0));
    send_word(32'h403100B3);
    check_out();
    sb.push_back(mk(32'hFFF00293, 4'b0000, 4'd5, 4'd0, 4'd0, 32'hFFFFFFFF, 1'b1, 1'b0));
    send_word(32'hFFF00293);
    check_out();

    // SRAI and an illegal rd=x16
    sb.push_back(mk(32'h40325213, 4'b1101, 4'd4, 4'd4, 4'd0, 32'h00000003, 1'b1, 1'b0));
    send_word(32'h40325213);
    check_out();
    sb.push_back(mk(32'h00310833, 4'b0000, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b1));
    send_word(32'h00310833);
    check_out();

    // Backpressure with upstream still offering bytes
    sb.push_back(mk(32'h003100B3, 4'b0000, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0, 1'b0));
    send_word(32'h003100B3);
    byte_in    = 8'hAA;
    byte_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_byte_ready", {31'd0, byte_ready}, 32'd0);
      chk("bp_dec_valid", {31'd0, dec_valid}, 32'd1);
      chk("bp_instr", instr, 32'h003100B3);
    end
    byte_valid = 1'b0;
    check_out();

    // Abort after two bytes, then a fresh word
    send_byte(8'hFF);
    send_byte(8'hFF);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_collect_dv", {31'd0, dec_valid}, 32'd0);
    chk("abort_collect_br", {31'd0, byte_ready}, 32'd1);
    sb.push_back(mk(32'h003100B3, 4'b0000, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0, 1'b0));
    send_word(32'h003100B3);
    check_out();

    // Abort during HOLD discards the held word but keeps the fields
    send_word(32'h40325213);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_hold_dv", {31'd0, dec_valid}, 32'd0);
    chk("abort_hold_br", {31'd0, byte_ready}, 32'd1);
    chk("abort_hold_instr", instr, 32'h40325213);
    chk("abort_hold_alu", {28'd0, alu_op}, 32'd13);

    // Reset mid-collection
    send_byte(8'h13);
    send_byte(8'h52);
    send_byte(8'h32);
    #2;
    rst_n = 1'b0;
    #1;
    snap = imm;
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("midrst_alu", {28'd0, alu_op}, 32'd0);
    chk("midrst_imm", snap, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(mk(32'h403100B3, 4'b1000, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0, 1'b0));
    send_word(32'h403100B3);
    check_out();

    // Byte stream 00,31,00,B3: big-endian instance sees ADD, little-endian sees opcode 0
    send_byte(8'h00);
    send_byte(8'h31);
    send_byte(8'h00);
    send_byte(8'hB3);
    chk("be_dec_valid", {31'd0, be_dec_valid}, 32'd1);
    chk("be_instr", be_instr, 32'h003100B3);
    chk("be_alu", {28'd0, be_alu_op}, 32'd0);
    chk("be_rd", {28'd0, be_rd}, 32'd1);
    chk("be_rs1", {28'd0, be_rs1}, 32'd2);
    chk("be_rs2", {28'd0, be_rs2}, 32'd3);
    chk("be_illegal", {31'd0, be_illegal}, 32'd0);
    sb.push_back(mk(32'hB3003100, 4'b0000, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b1));
    check_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
